// File: rtl/grp_buf_arb_pkg.sv
// rtl/grp_buf_arb_pkg.sv - shared types, constants and helpers for the group buffer arbiter
package grp_buf_arb_pkg;

    // Default geometry of the orbit group memory port
    localparam int N_REQ_DEF       = 5;
    localparam int DW_DEF          = 12;
    localparam int AW_DEF          = 10;
    localparam int MAX_HOLD_DEF    = 1024;
    localparam int SWAP_GUARD_DEF  = 4;
    localparam int SYNC_STAGES_DEF = 2;

    // Requester index width; the arbiter supports up to 8 requesters
    localparam int IDX_W = 3;

    // Requester indices
    localparam int LCB1 = 0;
    localparam int LCB2 = 1;
    localparam int LCB3 = 2;
    localparam int LCB4 = 3;
    localparam int MCM  = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OWN  = 2'd1,
        ST_GAP  = 2'd2,
        ST_SWAP = 2'd3
    } arb_state_e;

    // Index of the (single) set bit of a one-hot vector; 0 when empty
    function automatic logic [IDX_W-1:0] onehot_to_idx(input logic [7:0] oh);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < 8; i++) begin
            if (oh[i]) begin
                idx = IDX_W'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/grp_buf_arbiter_rr_pick.sv
// rtl/grp_buf_arbiter_rr_pick.sv - combinational round-robin picker
//
// Ports:
//   req_i   - request vector
//   last_i  - index of the previous winner (lowest priority next round)
//   win_o   - one-hot winner, 0 when no request
//   valid_o - at least one request present
module rr_pick
    import grp_buf_arb_pkg::*;
#(
    parameter int N_REQ = N_REQ_DEF
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [IDX_W-1:0] last_i,
    output logic [N_REQ-1:0] win_o,
    output logic             valid_o
);

    logic [N_REQ-1:0] upper_mask;
    logic [N_REQ-1:0] upper_req;
    logic [N_REQ-1:0] cand;

    // Requesters above the last winner are served first; when none of them
    // asks, the scan wraps to the lowest-indexed requester.
    always_comb begin
        upper_mask = '0;
        for (int i = 0; i < N_REQ; i++) begin
            upper_mask[i] = (i > int'(last_i));
        end
    end

    assign upper_req = req_i & upper_mask;
    assign cand      = (|upper_req) ? upper_req : req_i;
    // Isolate the lowest set bit of the candidate set
    assign win_o     = cand & (~cand + N_REQ'(1));
    assign valid_o   = |req_i;

endmodule

// File: rtl/grp_buf_arbiter.sv
// rtl/grp_buf_arbiter.sv - owner arbiter for the shared orbit group memory write/RMW port
//
// Ports:
//   clk, reset                 - 80 MHz clock, synchronous active-high reset
//   req                        - per-requester ownership request (level)
//   wrd_in, wrd_addr_in,
//   wren_in, old_addr_in,
//   old_rden_in                - per-requester memory port signals, slice i = requester i
//   swch_async                 - frame-former buffer select from the clk12 domain
//   grant                      - registered one-hot owner
//   comm_*                     - owner's port signals, zero outside ownership
//   busy                       - owning or in swap guard
//   timeout, timeout_id        - forced-revoke pulse and index of the revoked owner
module grp_buf_arbiter
    import grp_buf_arb_pkg::*;
#(
    parameter int N_REQ       = N_REQ_DEF,
    parameter int DW          = DW_DEF,
    parameter int AW          = AW_DEF,
    parameter int MAX_HOLD    = MAX_HOLD_DEF,
    parameter int SWAP_GUARD  = SWAP_GUARD_DEF,
    parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [N_REQ-1:0]    req,
    input  logic [N_REQ*DW-1:0] wrd_in,
    input  logic [N_REQ*AW-1:0] wrd_addr_in,
    input  logic [N_REQ-1:0]    wren_in,
    input  logic [N_REQ*AW-1:0] old_addr_in,
    input  logic [N_REQ-1:0]    old_rden_in,
    input  logic                swch_async,
    output logic [N_REQ-1:0]    grant,
    output logic [DW-1:0]       comm_wrd,
    output logic [AW-1:0]       comm_addr,
    output logic                comm_wren,
    output logic [AW-1:0]       comm_old_addr,
    output logic                comm_old_rden,
    output logic                busy,
    output logic                timeout,
    output logic [2:0]          timeout_id
);

    localparam int HW = $clog2(MAX_HOLD + 1);
    localparam int GW = $clog2(SWAP_GUARD + 1);

    arb_state_e             state_q, state_d;
    logic [N_REQ-1:0]       grant_q, grant_d;
    logic [IDX_W-1:0]       rr_last_q, rr_last_d;
    logic [HW-1:0]          hold_q, hold_d;
    logic [GW-1:0]          guard_q, guard_d;
    logic                   swap_pend_q, swap_pend_d;
    logic                   timeout_q, timeout_d;
    logic [2:0]             timeout_id_q, timeout_id_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   swch_prev_q;

    logic                   swap_edge;
    logic [N_REQ-1:0]       pick_win;
    logic                   pick_valid;
    logic [7:0]             grant_ext;
    logic [7:0]             pick_ext;
    logic [IDX_W-1:0]       owner_idx;
    logic [IDX_W-1:0]       pick_idx;
    logic                   owner_req;

    rr_pick #(
        .N_REQ (N_REQ)
    ) u_rr_pick (
        .req_i   (req),
        .last_i  (rr_last_q),
        .win_o   (pick_win),
        .valid_o (pick_valid)
    );

    always_comb begin
        grant_ext = '0;
        grant_ext[N_REQ-1:0] = grant_q;
        pick_ext = '0;
        pick_ext[N_REQ-1:0] = pick_win;
    end

    assign owner_idx = onehot_to_idx(grant_ext);
    assign pick_idx  = onehot_to_idx(pick_ext);
    assign owner_req = |(req & grant_q);

    // Swap select crosses from clk12; either edge of the synchronized value
    // means the frame former has flipped buffers.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q      <= '0;
            swch_prev_q <= 1'b0;
        end else begin
            sync_q[0] <= swch_async;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                sync_q[s] <= sync_q[s-1];
            end
            swch_prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign swap_edge = sync_q[SYNC_STAGES-1] ^ swch_prev_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            grant_q      <= '0;
            rr_last_q    <= IDX_W'(N_REQ - 1);
            hold_q       <= '0;
            guard_q      <= '0;
            swap_pend_q  <= 1'b0;
            timeout_q    <= 1'b0;
            timeout_id_q <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            rr_last_q    <= rr_last_d;
            hold_q       <= hold_d;
            guard_q      <= guard_d;
            swap_pend_q  <= swap_pend_d;
            timeout_q    <= timeout_d;
            timeout_id_q <= timeout_id_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        rr_last_d    = rr_last_q;
        hold_d       = hold_q;
        guard_d      = guard_q;
        swap_pend_d  = swap_pend_q | swap_edge;
        timeout_d    = 1'b0;
        timeout_id_d = timeout_id_q;

        case (state_q)
            ST_IDLE, ST_GAP: begin
                // An edge seen this very cycle already counts as pending so a
                // simultaneous request cannot slip in ahead of the swap.
                if (swap_pend_q | swap_edge) begin
                    state_d = ST_SWAP;
                    guard_d = GW'(SWAP_GUARD - 1);
                    grant_d = '0;
                end else if (pick_valid) begin
                    state_d   = ST_OWN;
                    grant_d   = pick_win;
                    rr_last_d = pick_idx;
                    hold_d    = '0;
                end else begin
                    state_d = ST_IDLE;
                    grant_d = '0;
                end
            end
            ST_OWN: begin
                // Release is checked first so a voluntary drop on the last
                // allowed cycle is not reported as a timeout.
                if (!owner_req) begin
                    state_d = ST_GAP;
                    grant_d = '0;
                end else if (hold_q == HW'(MAX_HOLD - 1)) begin
                    state_d      = ST_GAP;
                    grant_d      = '0;
                    timeout_d    = 1'b1;
                    timeout_id_d = 3'(owner_idx);
                end else begin
                    hold_d = hold_q + HW'(1);
                end
            end
            ST_SWAP: begin
                grant_d = '0;
                if (swap_edge) begin
                    guard_d = GW'(SWAP_GUARD - 1);
                end else if (guard_q == '0) begin
                    state_d     = ST_IDLE;
                    swap_pend_d = 1'b0;
                end else begin
                    guard_d = guard_q - GW'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = '0;
            end
        endcase
    end

    // Owner's port signals; grant is one-hot so an OR-mux is sufficient
    always_comb begin
        comm_wrd      = '0;
        comm_addr     = '0;
        comm_wren     = 1'b0;
        comm_old_addr = '0;
        comm_old_rden = 1'b0;
        if (state_q == ST_OWN) begin
            for (int i = 0; i < N_REQ; i++) begin
                if (grant_q[i]) begin
                    comm_wrd      = comm_wrd      | wrd_in[i*DW +: DW];
                    comm_addr     = comm_addr     | wrd_addr_in[i*AW +: AW];
                    comm_wren     = comm_wren     | wren_in[i];
                    comm_old_addr = comm_old_addr | old_addr_in[i*AW +: AW];
                    comm_old_rden = comm_old_rden | old_rden_in[i];
                end
            end
        end
    end

    assign grant      = grant_q;
    assign busy       = (state_q == ST_OWN) || (state_q == ST_SWAP);
    assign timeout    = timeout_q;
    assign timeout_id = timeout_id_q;

endmodule

// File: tb/tb_grp_buf_arbiter.sv
// tb/tb_grp_buf_arbiter.sv - randomized and directed bench for grp_buf_arbiter
module tb_grp_buf_arbiter;

    localparam int N  = 5;
    localparam int DW = 12;
    localparam int AW = 10;
    localparam int MH = 1024;
    localparam int SG = 4;
    localparam int SS = 2;

    localparam int M_IDLE = 0;
    localparam int M_OWN  = 1;
    localparam int M_GAP  = 2;
    localparam int M_SWAP = 3;

    logic            clk = 1'b0;
    logic            reset;
    logic [N-1:0]    req;
    logic [N*DW-1:0] wrd_in;
    logic [N*AW-1:0] wrd_addr_in;
    logic [N-1:0]    wren_in;
    logic [N*AW-1:0] old_addr_in;
    logic [N-1:0]    old_rden_in;
    logic            swch_async;
    logic [N-1:0]    grant;
    logic [DW-1:0]   comm_wrd;
    logic [AW-1:0]   comm_addr;
    logic            comm_wren;
    logic [AW-1:0]   comm_old_addr;
    logic            comm_old_rden;
    logic            busy;
    logic            timeout;
    logic [2:0]      timeout_id;

    logic [DW-1:0]   d_wrd   [N];
    logic [AW-1:0]   d_addr  [N];
    logic [AW-1:0]   d_oaddr [N];

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state
    int m_mode;
    int m_owner;
    int m_hold;
    int m_guard;
    int m_rr;
    int m_tid;
    bit m_pend;
    bit m_tmo;
    bit m_hist[$];

    // Observation helpers for directed phases
    bit           rec_on;
    int           grant_seq[$];
    logic [N-1:0] last_g;
    int           tmo_seen;

    always #5 clk = ~clk;

    always_comb begin
        wrd_in      = '0;
        wrd_addr_in = '0;
        old_addr_in = '0;
        for (int i = 0; i < N; i++) begin
            wrd_in[i*DW +: DW]      = d_wrd[i];
            wrd_addr_in[i*AW +: AW] = d_addr[i];
            old_addr_in[i*AW +: AW] = d_oaddr[i];
        end
    end

    grp_buf_arbiter #(
        .N_REQ       (N),
        .DW          (DW),
        .AW          (AW),
        .MAX_HOLD    (MH),
        .SWAP_GUARD  (SG),
        .SYNC_STAGES (SS)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .req           (req),
        .wrd_in        (wrd_in),
        .wrd_addr_in   (wrd_addr_in),
        .wren_in       (wren_in),
        .old_addr_in   (old_addr_in),
        .old_rden_in   (old_rden_in),
        .swch_async    (swch_async),
        .grant         (grant),
        .comm_wrd      (comm_wrd),
        .comm_addr     (comm_addr),
        .comm_wren     (comm_wren),
        .comm_old_addr (comm_old_addr),
        .comm_old_rden (comm_old_rden),
        .busy          (busy),
        .timeout       (timeout),
        .timeout_id    (timeout_id)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic m_reset();
        m_mode  = M_IDLE;
        m_owner = -1;
        m_hold  = 0;
        m_guard = 0;
        m_rr    = N - 1;
        m_tid   = 0;
        m_pend  = 0;
        m_tmo   = 0;
        m_hist.delete();
        for (int k = 0; k <= SS; k++) m_hist.push_back(1'b0);
    endtask

    // One clock edge of the arbitration rules, using the inputs present at that edge
    task automatic m_step();
        bit edge_c;
        bit found;
        int c;
        m_tmo = 0;
        if (reset) begin
            m_reset();
            return;
        end
        // synchronized value = sample SS edges old; edge = it differs from the one before
        edge_c = (m_hist[SS-1] != m_hist[SS]);
        m_hist.push_front(swch_async);
        void'(m_hist.pop_back());
        case (m_mode)
            M_IDLE, M_GAP: begin
                if (m_pend || edge_c) begin
                    m_mode  = M_SWAP;
                    m_guard = SG - 1;
                    m_pend  = 1;
                end else if (req != '0) begin
                    found = 0;
                    for (int k = 1; k <= N; k++) begin
                        c = (m_rr + k) % N;
                        if (!found && req[c]) begin
                            found   = 1;
                            m_owner = c;
                        end
                    end
                    m_rr   = m_owner;
                    m_hold = 0;
                    m_mode = M_OWN;
                end else begin
                    m_mode = M_IDLE;
                end
            end
            M_OWN: begin
                if (edge_c) m_pend = 1;
                if (!req[m_owner]) begin
                    m_owner = -1;
                    m_mode  = M_GAP;
                end else if (m_hold == MH - 1) begin
                    m_tmo   = 1;
                    m_tid   = m_owner;
                    m_owner = -1;
                    m_mode  = M_GAP;
                end else begin
                    m_hold++;
                end
            end
            default: begin
                if (edge_c) begin
                    m_guard = SG - 1;
                end else if (m_guard == 0) begin
                    m_pend = 0;
                    m_mode = M_IDLE;
                end else begin
                    m_guard--;
                end
            end
        endcase
    endtask

    task automatic check_outputs();
        logic [N-1:0]  eg;
        logic [DW-1:0] ew;
        logic [AW-1:0] ea;
        logic [AW-1:0] eoa;
        logic          ewe;
        logic          erd;
        eg = '0; ew = '0; ea = '0; eoa = '0; ewe = 1'b0; erd = 1'b0;
        if (m_owner >= 0) begin
            eg[m_owner] = 1'b1;
            ew  = d_wrd[m_owner];
            ea  = d_addr[m_owner];
            eoa = d_oaddr[m_owner];
            ewe = wren_in[m_owner];
            erd = old_rden_in[m_owner];
        end
        check("grant",         32'(grant),         32'(eg));
        check("busy",          32'(busy),          32'((m_mode == M_OWN) || (m_mode == M_SWAP)));
        check("timeout",       32'(timeout),       32'(m_tmo));
        check("timeout_id",    32'(timeout_id),    32'(m_tid));
        check("comm_wrd",      32'(comm_wrd),      32'(ew));
        check("comm_addr",     32'(comm_addr),     32'(ea));
        check("comm_wren",     32'(comm_wren),     32'(ewe));
        check("comm_old_addr", 32'(comm_old_addr), 32'(eoa));
        check("comm_old_rden", 32'(comm_old_rden), 32'(erd));
    endtask

    task automatic rand_data();
        for (int i = 0; i < N; i++) begin
            d_wrd[i]   = DW'($urandom);
            d_addr[i]  = AW'($urandom);
            d_oaddr[i] = AW'($urandom);
        end
        wren_in     = N'($urandom);
        old_rden_in = N'($urandom);
    endtask

    task automatic cycle();
        rand_data();
        @(negedge clk);
        check_outputs();
        if (timeout) tmo_seen++;
        if (rec_on && grant != '0 && grant != last_g) begin
            for (int i = 0; i < N; i++) if (grant[i]) grant_seq.push_back(i);
        end
        last_g = grant;
        @(posedge clk);
        m_step();
        #1;
    endtask

    task automatic do_reset();
        reset      = 1'b1;
        req        = '0;
        swch_async = 1'b0;
        repeat (2) cycle();
        reset = 1'b0;
    endtask

    initial begin
        int exp_order[6];
        exp_order  = '{0, 1, 2, 3, 4, 0};
        reset      = 1'b1;
        req        = '0;
        swch_async = 1'b0;
        rec_on     = 1'b0;
        last_g     = '0;
        tmo_seen   = 0;
        m_reset();
        rand_data();
        @(posedge clk);
        #1;
        do_reset();

        // Single requester 0: grant, release through GAP, back to IDLE
        req = 5'b00001;
        repeat (4) cycle();
        req = '0;
        repeat (3) cycle();

        // All requesting, each owner releases after 3 cycles: fair rotation
        do_reset();
        rec_on = 1'b1;
        grant_seq.delete();
        for (int c = 0; c < 40; c++) begin
            req = '1;
            if (m_owner >= 0 && m_hold == 2) req[m_owner] = 1'b0;
            cycle();
        end
        rec_on = 1'b0;
        check("rr_order_len", 32'(grant_seq.size() >= 6), 32'(1));
        for (int k = 0; k < 6 && k < grant_seq.size(); k++) begin
            check("rr_order", 32'(grant_seq[k]), 32'(exp_order[k]));
        end

        // Owner 2 overstays: forced revoke, then requester 3 wins
        do_reset();
        tmo_seen = 0;
        req = 5'b01100;
        repeat (MH + 10) cycle();
        req[2] = 1'b0;
        repeat (5) cycle();
        check("tmo_pulses", 32'(tmo_seen), 32'(1));
        check("tmo_id", 32'(timeout_id), 32'(2));
        check("post_tmo_grant", 32'(grant), 32'(5'b01000));
        req = '0;
        repeat (3) cycle();

        // Swap edge while requester 1 owns: no preemption, guard after release
        do_reset();
        req = 5'b00010;
        repeat (2) cycle();
        swch_async = ~swch_async;
        repeat (6) cycle();
        req = 5'b10000;
        repeat (12) cycle();
        check("swap_then_mcm", 32'(grant), 32'(5'b10000));
        req = '0;
        repeat (3) cycle();

        // Swap edge and a new request land in the same IDLE cycle
        do_reset();
        swch_async = 1'b1;
        repeat (2) cycle();
        req = 5'b00100;
        cycle();
        check("swap_first", 32'(grant), 32'(0));
        check("swap_busy", 32'(busy), 32'(1));
        repeat (10) cycle();
        req = '0;
        repeat (3) cycle();

        // Reset during MCM ownership drops grant at that edge
        do_reset();
        req = 5'b10000;
        repeat (3) cycle();
        reset = 1'b1;
        cycle();
        check("rst_drop", 32'(grant), 32'(0));
        reset = 1'b0;
        req   = 5'b10001;
        cycle();
        check("rst_req0_wins", 32'(grant), 32'(5'b00001));
        repeat (3) cycle();

        // Random traffic, swaps and occasional resets against the model
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(7) == 0) req[i] = ~req[i];
            end
            if ($urandom_range(39) == 0) swch_async = ~swch_async;
            reset = ($urandom_range(499) == 0);
            cycle();
        end
        reset = 1'b0;
        repeat (2) cycle();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/grp_buf_arbiter.md
Name: grp_buf_arbiter

Overview:
Arbitrates the shared write and read-modify-write port of the double-buffered orbit group memory between five requesters: LCB1..LCB4 word assemblers and the MCM packer.
- Grants whole-transaction ownership with a request/hold/release handshake and round-robin fairness.
- Muxes the winner's address, data and enables onto the common memory port.
- Blocks new grants around frame-former buffer swaps.
- Revokes an owner that holds the port too long.
- Sits between the requesters and the buffer-swap mux, in the clk80 domain.

Parameters:
N_REQ, 5, number of requesters (index 4 = MCM)
DW, 12, orbit word width
AW, 10, group buffer address width
MAX_HOLD, 1024, max cycles one owner may hold the grant
SWAP_GUARD, 4, idle cycles enforced after a swap edge
SYNC_STAGES, 2, synchronizer depth for the swap input

Ports:
clk  in  1  system clock (80 MHz)
reset  in  1  synchronous, active-high
req  in  N_REQ  per-requester ownership request, level, held for whole transaction
wrd_in  in  N_REQ*DW  per-requester write data, slice i = requester i
wrd_addr_in  in  N_REQ*AW  per-requester write address
wren_in  in  N_REQ  per-requester write enable
old_addr_in  in  N_REQ*AW  per-requester read address (read-modify-write)
old_rden_in  in  N_REQ  per-requester read enable
swch_async  in  1  frame-former buffer select (clk12 domain)
grant  out  N_REQ  one-hot ownership, registered
comm_wrd  out  DW  muxed write data
comm_addr  out  AW  muxed write address
comm_wren  out  1  muxed write enable
comm_old_addr  out  AW  muxed read address
comm_old_rden  out  1  muxed read enable
busy  out  1  grant held or swap guard active
timeout  out  1  one-cycle pulse on forced revoke
timeout_id  out  3  index of revoked requester, held until next timeout

Behaviour:
- Reset (synchronous): all outputs 0; state IDLE; swap_pending 0; hold counter 0; rr_last = N_REQ-1, so requester 0 has first priority; synchronizer flops cleared. Reset asserted mid-transaction drops grant at that edge, with no gap cycle.
- Swap detect: swch_async passes through SYNC_STAGES flops. Any edge (either direction) of the synchronized value sets swap_pending.
- States:
  - IDLE/GAP:
    - If swap_pending: go to SWAP and load guard counter = SWAP_GUARD-1.
    - Else if any req: pick the first set req scanning rr_last+1, +2, ... (wrapping), register one-hot grant, set rr_last = winner, clear hold counter, go to OWN.
    - Else stay in IDLE.
  - OWN:
    - comm_* = slice of winner; comm_wren/comm_old_rden = winner's enables.
    - Hold counter increments each cycle.
    - req[owner] low: clear grant, go to GAP.
    - Hold counter == MAX_HOLD-1 with req still high: clear grant, pulse timeout, latch timeout_id, go to GAP.
    - Release and timeout in the same cycle: release wins, no timeout.
    - A swap edge during OWN does not preempt; it stays pending.
  - GAP: exactly one cycle. All comm_* are 0. Arbitration then runs as in IDLE.
  - SWAP: no grants. Guard counter decrements each cycle. At 0: clear swap_pending, go to IDLE. A further swap edge during SWAP reloads the guard counter.
- Outside OWN, all comm_* outputs are forced to 0.
- Latency:
  - req rising in IDLE at edge n → grant at edge n+1.
  - Release at n → GAP at n+1 → next grant at n+2.
- Priority: swap_pending beats requests when both are present in IDLE/GAP.
- A requester whose req was already deasserted when grant arrives releases normally through GAP; the grant lasts one cycle.
- busy = (state==OWN) | (state==SWAP).

Decomposition:
- Package grp_buf_arb_pkg: state enum (IDLE, OWN, GAP, SWAP), requester index constants (LCB1..LCB4 = 0..3, MCM = 4), default widths.
- Sub-module rr_pick: combinational round-robin picker. Inputs: req vector and last index. Outputs: one-hot winner and valid.

Test Plan:
- After reset, req=5'b00001 → grant=00001 at next edge. comm_addr follows wrd_addr_in slice 0. Drop req → GAP with comm_wren=0, then IDLE.
- req=5'b11111 held constantly, each owner holding 3 cycles → grant order 0,1,2,3,4,0, each grant separated by exactly one GAP cycle.
- Owner 2 holds req for MAX_HOLD+10 cycles → grant revoked after MAX_HOLD cycles, timeout pulse, timeout_id=2. Next grant goes to requester 3 if it is requesting.
- swch_async toggles while owner 1 is in OWN → owner continues. After its release, SWAP lasts SWAP_GUARD cycles with grant=0 and busy=1 despite pending req=5'b10000, then grant=10000.
- Swap edge and new req arrive at the same IDLE cycle → SWAP taken first; grant appears only after the guard expires.
- reset asserted during OWN of requester 4 → grant=0 at that edge. After release of reset, req=5'b10001 → requester 0 wins.
